// File: rtl/wdg_monitor_n_if.sv
// Supervisor-side bundle for the N-channel heartbeat watchdog.
// master = system/bench side, slave = watchdog side.
interface wdg_monitor_n_if #(
  parameter int N_CH  = 2,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  heartbeat;
  logic             retry_clr;
  logic [N_CH-1:0]  reset_uc;
  logic [SEL_W-1:0] selected_proc;
  logic             failover;
  logic [N_CH-1:0]  alive;
  logic             all_failed;

  modport master (
    output heartbeat, retry_clr,
    input  reset_uc, selected_proc, failover, alive, all_failed
  );
  modport slave (
    input  heartbeat, retry_clr,
    output reset_uc, selected_proc, failover, alive, all_failed
  );
endinterface

// File: rtl/wdg_monitor_n.sv
// N-channel heartbeat watchdog: per-channel BOOT/MONITOR/FAULT/DEAD supervision
// plus non-preemptive failover of the controlling processor.

module wdg_monitor_n_ch #(
  parameter int TIMEOUT   = 16,
  parameter int GRACE     = 32,
  parameter int RST_PULSE = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 6,
  parameter int FC_W      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_edge,
  input  logic i_clr,
  output logic o_nxt_mon,
  output logic o_nxt_dead,
  output logic o_uc,
  output logic o_alive
);
  typedef enum logic [1:0] {S_BOOT, S_MON, S_FAULT, S_DEAD} st_t;

  st_t             r_st, w_st_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [FC_W-1:0]  r_fc, w_fc_nxt;
  logic             w_uc, w_alive;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st    <= S_BOOT;
      r_cnt   <= '0;
      r_fc    <= '0;
      o_uc    <= 1'b0;
      o_alive <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fc    <= w_fc_nxt;
      o_uc    <= w_uc;
      o_alive <= w_alive;
    end
  end

  // An edge always beats counter expiry in the same cycle.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt + 1'b1;
    w_fc_nxt  = r_fc;
    case (r_st)
      S_BOOT: begin
        if (i_edge) begin
          w_st_nxt  = S_MON;
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(GRACE-1)) begin
          w_st_nxt  = S_FAULT;
          w_cnt_nxt = '0;
        end
      end
      S_MON: begin
        if (i_edge) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
          w_st_nxt  = S_FAULT;
          w_cnt_nxt = '0;
        end
      end
      S_FAULT: begin
        if (r_cnt == CNT_W'(RST_PULSE-1)) begin
          w_cnt_nxt = '0;
          w_st_nxt  = (r_fc == FC_W'(MAX_RETRY)) ? S_DEAD : S_BOOT;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        if (i_clr) w_st_nxt = S_BOOT;
      end
    endcase
    if (w_st_nxt == S_FAULT && r_st != S_FAULT && r_fc != FC_W'(MAX_RETRY))
      w_fc_nxt = r_fc + 1'b1;
    if (i_clr) w_fc_nxt = '0;
  end

  always_comb begin
    w_uc       = (w_st_nxt == S_FAULT) || (w_st_nxt == S_DEAD);
    w_alive    = (w_st_nxt == S_MON);
    o_nxt_mon  = (w_st_nxt == S_MON);
    o_nxt_dead = (w_st_nxt == S_DEAD);
  end
endmodule

module wdg_monitor_n #(
  parameter int N_CH      = 2,
  parameter int TIMEOUT   = 16,
  parameter int GRACE     = 32,
  parameter int RST_PULSE = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            reset,
  wdg_monitor_n_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int M1    = (TIMEOUT > GRACE) ? TIMEOUT : GRACE;
  localparam int MAXC  = (M1 > RST_PULSE) ? M1 : RST_PULSE;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int FC_W  = $clog2(MAX_RETRY + 1);

  logic [N_CH-1:0]  r_sync1, r_sync2, r_hb_d;
  logic [N_CH-1:0]  w_edge, w_mon_nxt, w_dead_nxt, w_uc, w_alive;
  logic [SEL_W-1:0] r_sel, w_hi_pick, w_lo_pick;
  logic             r_fo, r_af, w_hi_found, w_lo_found, w_sw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hb_d  <= '0;
    end else begin
      r_sync1 <= bus.heartbeat;
      r_sync2 <= r_sync1;
      r_hb_d  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_hb_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wdg_monitor_n_ch #(
      .TIMEOUT(TIMEOUT), .GRACE(GRACE), .RST_PULSE(RST_PULSE),
      .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W), .FC_W(FC_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_edge    (w_edge[g]),
      .i_clr     (bus.retry_clr),
      .o_nxt_mon (w_mon_nxt[g]),
      .o_nxt_dead(w_dead_nxt[g]),
      .o_uc      (w_uc[g]),
      .o_alive   (w_alive[g])
    );
  end

  // Cyclic search from r_sel+1: lowest healthy index above r_sel wins,
  // otherwise wrap to the lowest healthy index below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_pick  = r_sel;
    w_lo_pick  = r_sel;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (w_mon_nxt[i] && SEL_W'(i) > r_sel) begin
        w_hi_found = 1'b1;
        w_hi_pick  = SEL_W'(i);
      end
      if (w_mon_nxt[i] && SEL_W'(i) < r_sel) begin
        w_lo_found = 1'b1;
        w_lo_pick  = SEL_W'(i);
      end
    end
    w_sw = !w_mon_nxt[r_sel] && (w_hi_found || w_lo_found);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel <= '0;
      r_fo  <= 1'b0;
      r_af  <= 1'b0;
    end else begin
      if (w_sw) r_sel <= w_hi_found ? w_hi_pick : w_lo_pick;
      r_fo <= w_sw;
      r_af <= &w_dead_nxt;
    end
  end

  assign bus.reset_uc      = w_uc;
  assign bus.alive         = w_alive;
  assign bus.selected_proc = r_sel;
  assign bus.failover      = r_fo;
  assign bus.all_failed    = r_af;
endmodule

// File: tb/tb_wdg_monitor_n.sv
// Scenario bench for wdg_monitor_n (defaults, N_CH=2): expected output records
// are queued per cycle and compared at the falling edge after each rising edge.
module tb_wdg_monitor_n;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wdg_monitor_n_if #(.N_CH(2)) bus ();
  wdg_monitor_n #(.N_CH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  // {reset_uc[1:0], selected_proc, failover, alive[1:0], all_failed}
  wire [6:0] w_out = {bus.reset_uc, bus.selected_proc, bus.failover, bus.alive, bus.all_failed};

  typedef struct {
    int         scn;
    int         cyc;
    logic [1:0] uc;
    logic       sel;
    logic       fo;
    logic [1:0] al;
    logic       af;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(int s, int c, logic [1:0] uc, logic sel, logic fo, logic [1:0] al, logic af);
    vec_t v;
    v.scn = s; v.cyc = c; v.uc = uc; v.sel = sel; v.fo = fo; v.al = al; v.af = af;
    tbl.push_back(v);
  endtask

  task automatic cmp(string nm, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got uc/sel/fo/alive/af=%b expected %b", nm, act, exp);
    end
  endtask

  // Pin toggles are applied at the falling edge just before rising edge c.
  function automatic bit hb_tog(int s, int ch, int c);
    case (s)
      1:       return (c % 5 == 0);
      2, 5, 6: return (ch == 1) ? (c % 5 == 0) : (c % 5 == 0 && c <= 20);
      3:       return (ch == 1) && c >= 118 && ((c - 118) % 5 == 0);
      4:       return (ch == 1) ? (c % 5 == 0) : (c == 5 || c == 21 || c == 37);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run(int s, int endc, int clr_c, int rst_at);
    vec_t e;
    logic [1:0] hb;
    reset = 1'b0;
    hb = 2'b00;
    bus.heartbeat = hb;
    bus.retry_clr = 1'b0;
    repeat (2) @(negedge clk);
    cmp($sformatf("s%0d_reset_values", s), w_out, 7'b0);
    reset = 1'b1;
    for (int c = 1; c <= endc; c++) begin
      for (int ch = 0; ch < 2; ch++)
        if (hb_tog(s, ch, c)) hb[ch] = ~hb[ch];
      bus.heartbeat = hb;
      bus.retry_clr = (c == clr_c);
      foreach (tbl[i])
        if (tbl[i].scn == s && tbl[i].cyc == c) sb.push_back(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        cmp($sformatf("s%0d_cyc%0d", s, c), w_out, {e.uc, e.sel, e.fo, e.al, e.af});
      end
      if (c == rst_at) begin
        #2 reset = 1'b0;
        #1 cmp($sformatf("s%0d_async_reset_cyc%0d", s, c), w_out, 7'b0);
        break;
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp($sformatf("s%0d_unreached_cyc%0d", s, e.cyc), 7'h7f, {e.uc, e.sel, e.fo, e.al, e.af});
    end
  endtask

  initial begin
    bus.heartbeat = '0;
    bus.retry_clr = 1'b0;

    // 1: both toggle every 5 cycles; first edges seen at cycle 7
    add(1, 6, 2'b00, 0, 0, 2'b00, 0);
    for (int c = 7; c <= 60; c++) add(1, c, 2'b00, 0, 0, 2'b11, 0);

    // 2: ch0 last edge detected at 22 -> three faults -> DEAD -> retry_clr at 120
    add(2, 37,  2'b00, 0, 0, 2'b11, 0);
    add(2, 38,  2'b01, 1, 1, 2'b10, 0);
    add(2, 39,  2'b01, 1, 0, 2'b10, 0);
    add(2, 41,  2'b01, 1, 0, 2'b10, 0);
    add(2, 42,  2'b00, 1, 0, 2'b10, 0);
    add(2, 73,  2'b00, 1, 0, 2'b10, 0);
    add(2, 74,  2'b01, 1, 0, 2'b10, 0);
    add(2, 77,  2'b01, 1, 0, 2'b10, 0);
    add(2, 78,  2'b00, 1, 0, 2'b10, 0);
    add(2, 109, 2'b00, 1, 0, 2'b10, 0);
    add(2, 110, 2'b01, 1, 0, 2'b10, 0);
    add(2, 114, 2'b01, 1, 0, 2'b10, 0);
    add(2, 119, 2'b01, 1, 0, 2'b10, 0);
    add(2, 120, 2'b00, 1, 0, 2'b10, 0);
    add(2, 125, 2'b00, 1, 0, 2'b10, 0);

    // 3: both silent -> both DEAD at 108; retry_clr at 115; ch1 revived at 120
    add(3, 31,  2'b00, 0, 0, 2'b00, 0);
    add(3, 32,  2'b11, 0, 0, 2'b00, 0);
    add(3, 35,  2'b11, 0, 0, 2'b00, 0);
    add(3, 36,  2'b00, 0, 0, 2'b00, 0);
    add(3, 68,  2'b11, 0, 0, 2'b00, 0);
    add(3, 104, 2'b11, 0, 0, 2'b00, 0);
    add(3, 107, 2'b11, 0, 0, 2'b00, 0);
    add(3, 108, 2'b11, 0, 0, 2'b00, 1);
    add(3, 114, 2'b11, 0, 0, 2'b00, 1);
    add(3, 115, 2'b00, 0, 0, 2'b00, 0);
    add(3, 119, 2'b00, 0, 0, 2'b00, 0);
    add(3, 120, 2'b00, 1, 1, 2'b10, 0);
    add(3, 121, 2'b00, 1, 0, 2'b10, 0);

    // 4: ch0 edges exactly at cnt==TIMEOUT-1 (23, 39), then silent -> fault at 55
    add(4, 23, 2'b00, 0, 0, 2'b11, 0);
    add(4, 39, 2'b00, 0, 0, 2'b11, 0);
    add(4, 54, 2'b00, 0, 0, 2'b11, 0);
    add(4, 55, 2'b01, 1, 1, 2'b10, 0);

    // 5/6: async reset during the failover cycle and during the reset_uc pulse
    add(5, 38, 2'b01, 1, 1, 2'b10, 0);
    add(6, 40, 2'b01, 1, 0, 2'b10, 0);

    run(1, 60, 0, 0);
    run(2, 125, 120, 0);
    run(3, 121, 115, 0);
    run(4, 56, 0, 0);
    run(5, 40, 0, 38);
    run(6, 42, 0, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
